edge_pulse_gen: RTL

//  Inverse of the positive-edge detector: turns single-cycle event strobes (pe) back into a

---
 rtl/edge_pulse_gen_pkg.sv | 18 +
 rtl/edge_pulse_gen_sat_counter.sv | 34 +++
 rtl/edge_pulse_gen.sv | 88 ++++++++
 3 files changed

// File: rtl/edge_pulse_gen_pkg.sv
// Shared types for the edge pulse generator: FSM state encoding and
// duration-counter sizing.
package edge_pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } epg_state_e;

    // Counter holds values up to max(h,l)-1; never narrower than one bit.
    function automatic int cnt_width(input int h, input int l);
        int m;
        m = (h > l) ? h : l;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/edge_pulse_gen_sat_counter.sv
// Saturating up/down counter for queued strobes; an increment at full scale
// is discarded and flagged on sat_drop in the same cycle.
module sat_updown_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_nxt,
    output logic             sat_drop
);

    localparam logic [WIDTH-1:0] MAX = '1;

    // inc and dec together cancel, so a full counter never drops in that case.
    always_comb begin
        count_nxt = count;
        sat_drop  = 1'b0;
        if (inc && !dec) begin
            if (count == MAX) sat_drop = 1'b1;
            else              count_nxt = count + WIDTH'(1);
        end else if (dec && !inc && count != '0) begin
            count_nxt = count - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else        count <= count_nxt;
    end

endmodule

// File: rtl/edge_pulse_gen.sv
// Converts single-cycle strobes into HIGH_CYCLES-wide pulses separated by at
// least LOW_CYCLES low cycles, queueing strobes that arrive mid-pulse.
module edge_pulse_gen
    import edge_pulse_gen_pkg::*;
#(
    parameter int HIGH_CYCLES = 2,
    parameter int LOW_CYCLES  = 1,
    parameter int PEND_W      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pe,
    output logic              sig,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              drop
);

    localparam int CNT_W = cnt_width(HIGH_CYCLES, LOW_CYCLES);

    if (HIGH_CYCLES < 1 || LOW_CYCLES < 1 || PEND_W < 1) begin : g_bad_param
        $error("edge_pulse_gen: HIGH_CYCLES, LOW_CYCLES and PEND_W must all be >= 1");
    end

    epg_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [PEND_W-1:0] pend_nxt;
    logic              start, inc, dec;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pe || pending != '0) start = 1'b1;
            end
            ST_HIGH: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = CNT_W'(LOW_CYCLES - 1);
                end
            end
            ST_LOW: begin
                if (cnt != '0)                  cnt_nxt   = cnt - CNT_W'(1);
                else if (pe || pending != '0)   start     = 1'b1;
                else                            state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (start) begin
            state_nxt = ST_HIGH;
            cnt_nxt   = CNT_W'(HIGH_CYCLES - 1);
        end
    end

    // A start serves the oldest queued strobe first; a same-cycle pe then
    // takes its place, and with an empty queue pe is consumed directly.
    assign dec = start && (pending != '0);
    assign inc = pe && !(start && pending == '0);

    sat_updown_counter #(.WIDTH(PEND_W)) u_pend (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (inc),
        .dec       (dec),
        .count     (pending),
        .count_nxt (pend_nxt),
        .sat_drop  (drop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sig   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sig   <= (state_nxt == ST_HIGH);
            busy  <= (state_nxt != ST_IDLE) || (pend_nxt != '0);
        end
    end

endmodule
